// File: rtl/string_uart_pkg.sv
// Shared types and defaults for the string-to-UART transmitter.
package string_uart_pkg;

    localparam int DEF_CLKS_PER_BIT  = 868;
    localparam int DEF_SETTLE_CYCLES = 2;

    typedef logic [7:0] char_t;

    localparam char_t NUL_CHAR = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LOAD,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        ADVANCE
    } tx_state_e;

endpackage

// File: rtl/string_uart_tx_if.sv
// Upstream character handshake plus serial outputs of the transmitter.
interface string_uart_tx_if;
    import string_uart_pkg::*;

    logic  start;
    char_t char_in;
    logic  char_done;
    logic  print_nxt;
    logic  tx;
    logic  busy;

    modport master (output start, char_in, char_done, input print_nxt, tx, busy);
    modport slave  (input start, char_in, char_done, output print_nxt, tx, busy);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter; bit_end marks the last clk of each serial bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bit_end = !restart && (cnt_q == LAST);

endmodule

// File: rtl/string_uart_tx.sv
// Streams an upstream-formatted string out as 8N1 UART frames, skipping NULs
// and requesting each next character with a one-cycle print_nxt pulse.
module string_uart_tx
    import string_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    string_uart_tx_if.slave   bus
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    tx_state_e  state_q;
    char_t      shreg_q;
    logic [2:0] idx_q;
    logic [3:0] settle_q;
    logic       hold_q;
    logic       tx_q;
    logic       busy_q;
    logic       pnxt_q;

    logic in_frame, bit_end;

    // Timer is held at zero outside a frame so START_BIT always begins on a fresh bit.
    assign in_frame = (state_q == START_BIT) || (state_q == DATA_BITS) || (state_q == STOP_BIT);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (!in_frame),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            settle_q <= '0;
            hold_q   <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            pnxt_q   <= 1'b0;
        end else begin
            pnxt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A held-high start must drop before another session may begin.
                    if (!bus.start) hold_q <= 1'b0;
                    else if (!hold_q) begin
                        state_q  <= SETTLE;
                        busy_q   <= 1'b1;
                        settle_q <= '0;
                    end
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) state_q <= LOAD;
                    else settle_q <= settle_q + 4'd1;
                end
                LOAD: begin
                    if (bus.char_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        hold_q  <= 1'b1;
                    end else if (bus.char_in == NUL_CHAR) begin
                        state_q <= ADVANCE;
                        pnxt_q  <= 1'b1;
                    end else begin
                        shreg_q <= bus.char_in;
                        tx_q    <= 1'b0;
                        state_q <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (bit_end) begin
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        idx_q   <= '0;
                        state_q <= DATA_BITS;
                    end
                end
                DATA_BITS: begin
                    if (bit_end) begin
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP_BIT;
                        end else begin
                            tx_q    <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                        end
                    end
                end
                STOP_BIT: begin
                    if (bit_end) begin
                        state_q <= ADVANCE;
                        pnxt_q  <= 1'b1;
                    end
                end
                ADVANCE: begin
                    state_q  <= SETTLE;
                    settle_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.print_nxt = pnxt_q;

endmodule

// File: tb/tb_string_uart_tx.sv
// Self-checking bench: behavioural upstream string source, UART frame decoder
// and per-scenario checks against frames/pulses predicted from the string.
module tb_string_uart_tx;
    import string_uart_pkg::*;

    localparam int CPB = 4;
    localparam int SET = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    string_uart_tx_if bus();

    string_uart_tx #(.CLKS_PER_BIT(CPB), .SETTLE_CYCLES(SET)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // upstream string source
    logic [7:0] str_mem [16];
    int         str_len  = 0;
    int         idx0     = 0;
    logic       ovr_en   = 1'b0;
    logic [7:0] ovr_char = 8'h00;
    logic       ovr_done = 1'b0;
    int         rel;

    // monitor state (written only by the monitor process)
    int          up_idx     = 0;
    int          pulses     = 0;
    int          busy_rises = 0;
    int          frame_err  = 0;
    int          mon_cnt    = -1;
    int          gap        = 0;
    int          max_gap    = 0;
    bit          gap_act    = 1'b0;
    logic        busy_prev  = 1'b0;
    logic [39:0] fr         = '0;
    logic [39:0] fr_last    = '0;
    logic [7:0]  mon_byte;
    logic [7:0]  rx_q [$];

    always_comb begin
        rel           = up_idx - idx0;
        bus.char_in   = 8'h00;
        bus.char_done = 1'b1;
        if (ovr_en) begin
            bus.char_in   = ovr_char;
            bus.char_done = ovr_done;
        end else if (rel >= 0 && rel < str_len) begin
            bus.char_in   = str_mem[rel[3:0]];
            bus.char_done = 1'b0;
        end
    end

    // Upstream advance, UART decoder, pulse/gap/session accounting.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_cnt   = -1;
            gap_act   = 1'b0;
            busy_prev = 1'b0;
        end else begin
            if (bus.busy && !busy_prev) busy_rises++;
            busy_prev = bus.busy;
            if (bus.print_nxt) begin
                pulses++;
                up_idx++;
                gap_act = 1'b1;
                gap     = 0;
            end
            if (!bus.busy) gap_act = 1'b0;
            if (mon_cnt < 0) begin
                if (bus.tx === 1'b0) begin
                    fr[0]   = 1'b0;
                    mon_cnt = 1;
                    if (gap_act && gap > max_gap) max_gap = gap;
                    gap_act = 1'b0;
                end else if (gap_act && !bus.print_nxt) gap++;
            end else if (mon_cnt < 40) begin
                fr[mon_cnt[5:0]] = bus.tx;
                mon_cnt++;
            end else begin
                if (bus.print_nxt !== 1'b1 || bus.tx !== 1'b1) frame_err++;
                for (int k = 0; k < 10; k++)
                    for (int j = 1; j < 4; j++)
                        if (fr[k*4+j] !== fr[k*4]) frame_err++;
                if (fr[0] !== 1'b0 || fr[36] !== 1'b1) frame_err++;
                for (int b = 0; b < 8; b++) mon_byte[b] = fr[(b+1)*4];
                rx_q.push_back(mon_byte);
                fr_last = fr;
                mon_cnt = -1;
            end
        end
    end

    // Ideal 8N1 waveform: start, 8 data LSB first, stop, each CPB cycles.
    function automatic logic [39:0] frame_of(input logic [7:0] b);
        logic [9:0]  bits;
        logic [39:0] f;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) f[i] = bits[i / CPB];
        return f;
    endfunction

    task automatic arm(input int n);
        str_len = n;
        idx0    = up_idx;
        ovr_en  = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.busy) begin to = 1'b0; break; end
        end
    endtask

    task automatic wait_start_bit(output bit to);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.tx === 1'b0) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.tx !== 1'b1)        begin errors++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.print_nxt !== 1'b0) begin errors++; $display("FAIL reset_pnxt: got %b want 0", bus.print_nxt); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.print_nxt !== 1'b0) begin
            errors++; $display("FAIL post_release_quiet: tx=%b busy=%b pnxt=%b want 1/0/0", bus.tx, bus.busy, bus.print_nxt);
        end
    endtask

    task automatic test_single_char();
        int rx0, p0, fe0, n;
        bit to;
        str_mem[0] = 8'h41; arm(1);
        rx0 = rx_q.size(); p0 = pulses; fe0 = frame_err;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL latency_busy: got %b want 1", bus.busy); end
        repeat (SET + 1) @(negedge clk);
        checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL latency_early: tx got %b want 1", bus.tx); end
        @(negedge clk);
        checks++; if (bus.tx !== 1'b0) begin errors++; $display("FAIL latency_start: tx got %b want 0", bus.tx); end
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.print_nxt) begin to = 1'b0; break; end
        end
        checks++; if (to) begin errors++; $display("FAIL single_pnxt_timeout: got none want pulse"); end
        n = 0; to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.busy) begin to = 1'b0; break; end
            n++;
        end
        checks++; if (to || n != SET + 2) begin errors++; $display("FAIL single_busy_fall: got %0d cycles (timeout=%0d) want %0d", n, to, SET + 2); end
        checks++; if (rx_q.size() != rx0 + 1) begin errors++; $display("FAIL single_count: got %0d frames want 1", rx_q.size() - rx0); end
        else begin
            checks++; if (fr_last !== frame_of(8'h41)) begin errors++; $display("FAIL single_wave: got %h want %h", fr_last, frame_of(8'h41)); end
        end
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", pulses - p0); end
        checks++; if (frame_err != fe0) begin errors++; $display("FAIL single_shape: got %0d bad want 0", frame_err - fe0); end
    endtask

    // Drive one session over str_mem[0..n-1]; expected output is the string minus NULs.
    task automatic run_string(input string tag, input int n);
        int rx0, p0, fe0, ne;
        bit to;
        logic [7:0] exp_q [$];
        for (int i = 0; i < n; i++) if (str_mem[i] != NUL_CHAR) exp_q.push_back(str_mem[i]);
        arm(n);
        rx0 = rx_q.size(); p0 = pulses; fe0 = frame_err;
        start_pulse();
        wait_idle(3000, to);
        checks++; if (to) begin errors++; $display("FAIL %s_timeout: busy stuck high", tag); end
        ne = exp_q.size();
        checks++; if (rx_q.size() - rx0 != ne) begin errors++; $display("FAIL %s_count: got %0d frames want %0d", tag, rx_q.size() - rx0, ne); end
        else for (int i = 0; i < ne; i++) begin
            checks++; if (rx_q[rx0+i] !== exp_q[i]) begin errors++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, rx_q[rx0+i], exp_q[i]); end
        end
        checks++; if (pulses - p0 != n) begin errors++; $display("FAIL %s_pulses: got %0d want %0d", tag, pulses - p0, n); end
        checks++; if (frame_err != fe0) begin errors++; $display("FAIL %s_shape: got %0d bad want 0", tag, frame_err - fe0); end
        checks++; if (max_gap > 4) begin errors++; $display("FAIL %s_gap: got %0d want <=4", tag, max_gap); end
    endtask

    task automatic test_string();
        str_mem[0] = 8'h32; str_mem[1] = 8'h30; str_mem[2] = 8'h34; str_mem[3] = 8'h38; str_mem[4] = 8'h0A;
        run_string("str2048", 5);
    endtask

    task automatic test_nul_skip();
        str_mem[0] = 8'h31; str_mem[1] = 8'h00; str_mem[2] = 8'h32;
        run_string("nul", 3);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++)
                str_mem[i] = ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
            run_string("rand", n);
        end
    endtask

    task automatic test_reset_mid_frame();
        int p0, txbad;
        bit to;
        str_mem[0] = 8'h01; arm(1);
        start_pulse();
        wait_start_bit(to);
        checks++; if (to) begin errors++; $display("FAIL rstmid_start_timeout: no start bit"); end
        repeat (4 * CPB + 1) @(negedge clk);
        checks++; if (bus.tx !== 1'b0) begin errors++; $display("FAIL rstmid_bit3: tx got %b want 0", bus.tx); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: tx=%b busy=%b want 1/0", bus.tx, bus.busy);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses; txbad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.print_nxt !== 1'b0) txbad++;
        end
        checks++; if (pulses != p0 || txbad != 0) begin
            errors++; $display("FAIL rstmid_quiet: pulses=%0d bad_cycles=%0d want 0/0", pulses - p0, txbad);
        end
    endtask

    task automatic test_start_held();
        int r0, rx0, p0;
        arm(0);
        r0 = busy_rises; rx0 = rx_q.size(); p0 = pulses;
        @(negedge clk); bus.start = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (busy_rises - r0 != 1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL held_one_session: got %0d sessions busy=%b want 1/0", busy_rises - r0, bus.busy);
        end
        bus.start = 1'b0;
        @(negedge clk); bus.start = 1'b1;
        repeat (30) @(negedge clk);
        bus.start = 1'b0;
        checks++; if (busy_rises - r0 != 2 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL held_rearm: got %0d sessions busy=%b want 2/0", busy_rises - r0, bus.busy);
        end
        checks++; if (rx_q.size() != rx0 || pulses != p0) begin
            errors++; $display("FAIL held_silent: frames=%0d pulses=%0d want 0/0", rx_q.size() - rx0, pulses - p0);
        end
    endtask

    task automatic test_mid_frame_change();
        int rx0, p0;
        bit to;
        str_mem[0] = 8'h55; str_mem[1] = 8'h66; arm(2);
        rx0 = rx_q.size(); p0 = pulses;
        start_pulse();
        wait_start_bit(to);
        checks++; if (to) begin errors++; $display("FAIL midchg_start_timeout: no start bit"); end
        repeat (10) @(negedge clk);
        ovr_char = 8'($urandom); ovr_done = 1'b0; ovr_en = 1'b1;
        repeat (27) @(negedge clk);
        ovr_char = ~ovr_char; ovr_done = 1'b1;
        wait_idle(500, to);
        ovr_en = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL midchg_timeout: busy stuck high"); end
        checks++; if (rx_q.size() - rx0 != 1) begin errors++; $display("FAIL midchg_count: got %0d frames want 1", rx_q.size() - rx0); end
        else begin
            checks++; if (fr_last !== frame_of(8'h55)) begin errors++; $display("FAIL midchg_wave: got %h want %h", fr_last, frame_of(8'h55)); end
        end
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL midchg_pulses: got %0d want 1", pulses - p0); end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_single_char();
        test_string();
        test_nul_skip();
        test_reset_mid_frame();
        test_start_held();
        test_mid_frame_change();
        test_random();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/string_uart_tx.md
STRING_UART_TX -- requirements
Module: string_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter SETTLE_CYCLES, default 2, wait after a print_nxt pulse before char_in is sampled; legal range 1..15.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; when sampled high in IDLE, begins a string transmission session.
REQ-006 char_in  input  8  current character from the upstream board-to-string formatter.
REQ-007 char_done  input  1  upstream reports that the string is exhausted.
REQ-008 print_nxt  output  1  single-cycle pulse requesting that upstream advance to its next character.
REQ-009 tx  output  1  UART serial line, 8N1, idle high.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 FSM states SHALL be: IDLE, SETTLE, LOAD, START_BIT, DATA_BITS, STOP_BIT, ADVANCE.
REQ-012 IDLE: tx=1, busy=0; start=1 -> SETTLE; start stays high across sessions without retriggering until a session ends (re-arm requires start=0 for at least 1 cycle in IDLE).
REQ-013 SETTLE: counts SETTLE_CYCLES cycles, then -> LOAD.
REQ-014 LOAD (1 cycle): char_done=1 -> IDLE; char_in==8'h00 -> ADVANCE (NUL is skipped, never transmitted); otherwise latch char_in into an 8-bit shift register -> START_BIT.
REQ-015 START_BIT: tx=0 for exactly CLKS_PER_BIT cycles -> DATA_BITS.
REQ-016 DATA_BITS: 8 bits LSB first, each held CLKS_PER_BIT cycles; a 3-bit index wraps 7->0 on exit -> STOP_BIT.
REQ-017 STOP_BIT: tx=1 for CLKS_PER_BIT cycles -> ADVANCE.
REQ-018 ADVANCE (1 cycle): print_nxt=1 -> SETTLE; print_nxt SHALL be 0 in every other state.
REQ-019 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles from the first tx=0 cycle to ADVANCE entry.
REQ-020 Latency: start sampled high at edge N -> LOAD at edge N+SETTLE_CYCLES+1 -> first tx=0 at edge N+SETTLE_CYCLES+2.
REQ-021 char_in changes during a frame SHALL NOT affect the frame in progress.
REQ-022 char_done rising mid-frame SHALL be ignored until the next LOAD; the current frame completes.
REQ-023 start is ignored outside IDLE.
REQ-024 Bit counter width SHALL be $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
REQ-025 tx SHALL be driven from a register (no combinational glitch).

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, tx=1, busy=0, print_nxt=0, shift register=0, all counters=0, start re-arm flag cleared.
REQ-027 Reset asserted mid-frame aborts the frame; after release tx stays 1 and no print_nxt is issued until a new session.
REQ-028 No output changes on the first clk edge after rst_n deasserts unless start=1.

Structure
REQ-029 Package string_uart_pkg SHALL hold the state enum, default CLKS_PER_BIT/SETTLE_CYCLES constants, and NUL_CHAR=8'h00.
REQ-030 One sub-module, uart_bit_timer (parameter CLKS_PER_BIT; inputs clk, rst_n, restart; output bit_end pulse), SHALL generate bit-period boundaries.
REQ-031 Top SHALL contain only the FSM, shift register, bit index, settle counter and re-arm flag.

Verification (CLKS_PER_BIT=4, SETTLE_CYCLES=2)
REQ-032 Single char: char_in=8'h41, start pulsed, char_done raised after first print_nxt -> tx = 0,1,0,0,0,0,0,1,0,1 each held 4 cycles; exactly 1 print_nxt; busy falls 4 cycles after the pulse.
REQ-033 String "2048\n" from a behavioural upstream -> decoded bytes 0x32,0x30,0x34,0x38,0x0A in order; 5 print_nxt pulses; no gap beyond 4 cycles between frames.
REQ-034 NUL skip: sequence 0x31,0x00,0x32 -> only 0x31,0x32 on tx; 3 print_nxt pulses; no frame emitted for the NUL.
REQ-035 Reset mid-frame: rst_n low during DATA_BITS bit 3 -> tx=1 and busy=0 in the same cycle; no print_nxt for 50 cycles with start=0.
REQ-036 Start held high: start=1 continuously, char_done=1 at first LOAD -> exactly 1 session; busy=0 thereafter; second session only after start drops and rises.
REQ-037 Mid-frame changes: char_in and char_done toggled during STOP_BIT of 0x55 -> frame bits unchanged (0,1,0,1,0,1,0,1,0,1); char_done then takes effect at the next LOAD.
